// File: rtl/uart_tx_scheduler.sv
// Two-requester byte scheduler: round-robin into a small FIFO,
// then a triggered handshake towards a UART monitor with a busy flag.
module uart_tx_scheduler #(
   parameter int FIFO_DEPTH   = 4,
   parameter int TRIG_WIDTH   = 2,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                          MCLK_IN,
   input  logic                          RUN_IN,
   input  logic                          REQ0_VALID_IN,
   input  logic [7:0]                    REQ0_BYTE_IN,
   output logic                          REQ0_READY,
   input  logic                          REQ1_VALID_IN,
   input  logic [7:0]                    REQ1_BYTE_IN,
   output logic                          REQ1_READY,
   input  logic                          UART_SEND_BUSY_IN,
   output logic                          UART_SEND_TRIGGER,
   output logic [7:0]                    UART_SEND_BYTE,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic                          TIMEOUT_ERR
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t        state;
   logic          busy_m;
   logic          busy_s;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          last;
   logic [7:0]    tcnt;
   logic [15:0]   wcnt;
   logic          full;
   logic          empty;
   logic          pop;
   logic          space;
   logic          gnt0;
   logic          gnt1;
   logic          acc0;
   logic          acc1;
   logic          push;
   logic [7:0]    wdata;

   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign pop   = (state == PULSE) && (tcnt == '0);
   // a full FIFO still takes a byte in the cycle its head leaves
   assign space = !full || pop;

   assign gnt0 = REQ0_VALID_IN && (!REQ1_VALID_IN || last);
   assign gnt1 = REQ1_VALID_IN && (!REQ0_VALID_IN || !last);

   assign REQ0_READY = RUN_IN && space && gnt0;
   assign REQ1_READY = RUN_IN && space && gnt1;

   assign acc0  = REQ0_READY && REQ0_VALID_IN;
   assign acc1  = REQ1_READY && REQ1_VALID_IN;
   assign push  = acc0 || acc1;
   assign wdata = acc0 ? REQ0_BYTE_IN : REQ1_BYTE_IN;

   assign FIFO_LEVEL = count;

   always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
      if (!RUN_IN) begin
         busy_m <= 1'b0;
         busy_s <= 1'b0;
      end else begin
         busy_m <= UART_SEND_BUSY_IN;
         busy_s <= busy_m;
      end
   end

   always_ff @(posedge MCLK_IN) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
      if (!RUN_IN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last   <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (acc0)      last <= 1'b0;
         else if (acc1) last <= 1'b1;
      end
   end

   always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
      if (!RUN_IN) begin
         state             <= IDLE;
         UART_SEND_TRIGGER <= 1'b0;
         UART_SEND_BYTE    <= 8'h00;
         TIMEOUT_ERR       <= 1'b0;
         tcnt              <= '0;
         wcnt              <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!empty && !busy_s) begin
                  UART_SEND_BYTE <= mem[rd_ptr];
                  state          <= SETUP;
               end
            end
            SETUP: begin
               UART_SEND_TRIGGER <= 1'b1;
               tcnt              <= '0;
               state             <= PULSE;
            end
            PULSE: begin
               if (tcnt == 8'(TRIG_WIDTH - 1)) begin
                  UART_SEND_TRIGGER <= 1'b0;
                  wcnt              <= '0;
                  state             <= WAIT_BUSY;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            WAIT_BUSY: begin
               if (busy_s) begin
                  state <= WAIT_DONE;
               end else if (wcnt == 16'(BUSY_TIMEOUT - 1)) begin
                  TIMEOUT_ERR <= 1'b1;
                  state       <= IDLE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!busy_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration, FIFO,
// sender handshake, timeout and reset behaviour.
module tb_uart_tx_scheduler;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_PULSE = 3'd2;
   localparam logic [2:0] S_WB    = 3'd3;
   localparam logic [2:0] S_WD    = 3'd4;

   logic       clk = 1'b0;
   logic       run;
   logic       v0;
   logic [7:0] b0;
   logic       r0;
   logic       v1;
   logic [7:0] b1;
   logic       r1;
   logic       busy;
   logic       trig;
   logic [7:0] sbyte;
   logic [2:0] level;
   logic       terr;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_scheduler dut (
      .MCLK_IN           (clk),
      .RUN_IN            (run),
      .REQ0_VALID_IN     (v0),
      .REQ0_BYTE_IN      (b0),
      .REQ0_READY        (r0),
      .REQ1_VALID_IN     (v1),
      .REQ1_BYTE_IN      (b1),
      .REQ1_READY        (r1),
      .UART_SEND_BUSY_IN (busy),
      .UART_SEND_TRIGGER (trig),
      .UART_SEND_BYTE    (sbyte),
      .FIFO_LEVEL        (level),
      .TIMEOUT_ERR       (terr)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [2:0] exp);
      logic [2:0] s;
      s = dut.state;
      chk(tag, 32'(s), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      run  = 1'b0;
      v0   = 1'b1;
      b0   = 8'h11;
      v1   = 1'b1;
      b1   = 8'h22;
      busy = 1'b0;
      #2;
      chk("rst_trig", 32'(trig), 0);
      chk("rst_byte", 32'(sbyte), 0);
      chk("rst_r0", 32'(r0), 0);
      chk("rst_r1", 32'(r1), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_err", 32'(terr), 0);
      step(2);
      v0  = 1'b0;
      v1  = 1'b0;
      run = 1'b1;

      // single byte with a well-behaved monitor
      v0 = 1'b1;
      b0 = 8'h41;
      #1;
      chk("t1_r0", 32'(r0), 1);
      step();
      v0 = 1'b0;
      chk("t1_level1", 32'(level), 1);
      chk_st("t1_idle0", S_IDLE);
      step();
      chk_st("t1_setup", S_SETUP);
      chk("t1_setup_byte", 32'(sbyte), 32'h41);
      chk("t1_setup_trig", 32'(trig), 0);
      step();
      chk("t1_trig_a", 32'(trig), 1);
      step();
      chk("t1_trig_b", 32'(trig), 1);
      chk("t1_pop_level", 32'(level), 0);
      step();
      chk("t1_trig_low", 32'(trig), 0);
      chk_st("t1_wb", S_WB);
      busy = 1'b1;
      step(10);
      chk_st("t1_wd", S_WD);
      busy = 1'b0;
      step(2);
      chk_st("t1_wd_hold", S_WD);
      step();
      chk_st("t1_idle", S_IDLE);
      chk("t1_level0", 32'(level), 0);
      chk("t1_byte_hold", 32'(sbyte), 32'h41);

      // round-robin fill with the sender stalled by busy
      run  = 1'b0;
      busy = 1'b1;
      step(2);
      run = 1'b1;
      step(2);
      v0 = 1'b1;
      b0 = 8'hA0;
      v1 = 1'b1;
      b1 = 8'hB0;
      #1;
      chk("t2_a0_r0", 32'(r0), 1);
      chk("t2_a0_r1", 32'(r1), 0);
      step();
      b0 = 8'hA1;
      #1;
      chk("t2_b0_r0", 32'(r0), 0);
      chk("t2_b0_r1", 32'(r1), 1);
      step();
      b1 = 8'hB1;
      #1;
      chk("t2_a1_r0", 32'(r0), 1);
      chk("t2_a1_r1", 32'(r1), 0);
      step();
      b0 = 8'hA2;
      #1;
      chk("t2_b1_r0", 32'(r0), 0);
      chk("t2_b1_r1", 32'(r1), 1);
      step();
      b1 = 8'hB2;
      #1;
      chk("t2_full_level", 32'(level), 4);
      chk("t2_full_r0", 32'(r0), 0);
      chk("t2_full_r1", 32'(r1), 0);
      step(2);
      chk("t2_hold_level", 32'(level), 4);
      chk("t2_hold_r0", 32'(r0), 0);
      chk("t2_hold_r1", 32'(r1), 0);
      chk_st("t2_hold_idle", S_IDLE);

      // full FIFO: REQ1 write lands in the pop cycle
      v0   = 1'b0;
      busy = 1'b0;
      #1;
      chk("t3_r1_blocked", 32'(r1), 0);
      step(3);
      chk_st("t3_setup", S_SETUP);
      chk("t3_setup_byte", 32'(sbyte), 32'hA0);
      chk("t3_setup_r1", 32'(r1), 0);
      step();
      chk("t3_pulse_trig", 32'(trig), 1);
      chk("t3_pop_r1", 32'(r1), 1);
      chk("t3_pop_level", 32'(level), 4);
      step();
      v1 = 1'b0;
      chk("t3_after_level", 32'(level), 4);
      chk("t3_byte_stable", 32'(sbyte), 32'hA0);

      // busy never rises: timeout, then the next byte still goes
      step();
      chk_st("t4_wb", S_WB);
      chk("t4_trig_low", 32'(trig), 0);
      step(15);
      chk("t4_err_early", 32'(terr), 0);
      chk_st("t4_wb_hold", S_WB);
      step();
      chk("t4_err_set", 32'(terr), 1);
      chk_st("t4_idle", S_IDLE);
      step();
      chk_st("t4_setup", S_SETUP);
      chk("t4_next_byte", 32'(sbyte), 32'hB0);
      step();
      chk("t4_next_trig", 32'(trig), 1);
      step();
      chk("t4_level3", 32'(level), 3);
      chk("t4_trig2", 32'(trig), 1);
      chk("t4_err_sticky", 32'(terr), 1);

      // reset in the second PULSE cycle
      run = 1'b0;
      #1;
      chk("t5_trig_drop", 32'(trig), 0);
      chk("t5_level0", 32'(level), 0);
      chk("t5_err_clr", 32'(terr), 0);
      chk("t5_byte_clr", 32'(sbyte), 0);
      #1;
      run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t5_quiet_trig", 32'(trig), 0);
         chk("t5_quiet_level", 32'(level), 0);
      end
      v0 = 1'b1;
      b0 = 8'h5A;
      #1;
      chk("t5_new_r0", 32'(r0), 1);
      step();
      v0 = 1'b0;
      chk("t5_new_level", 32'(level), 1);
      step();
      chk("t5_new_byte", 32'(sbyte), 32'h5A);
      step();
      chk("t5_new_trig", 32'(trig), 1);

      // busy already high at idle holds the sender off
      run  = 1'b0;
      busy = 1'b1;
      step();
      run = 1'b1;
      step(2);
      v0 = 1'b1;
      b0 = 8'hC3;
      #1;
      chk("t6_r0", 32'(r0), 1);
      step();
      v0 = 1'b0;
      chk("t6_level", 32'(level), 1);
      step(4);
      chk_st("t6_idle_busy", S_IDLE);
      chk("t6_trig", 32'(trig), 0);
      busy = 1'b0;
      step();
      chk_st("t6_idle_g1", S_IDLE);
      step();
      chk_st("t6_idle_g2", S_IDLE);
      step();
      chk_st("t6_setup", S_SETUP);
      chk("t6_byte", 32'(sbyte), 32'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
